rgb_palette_pwm: RTL and testbench

//   Parametrised RGB LED colour sequencer: 8-entry colour palette, 8-bit PWM per channel, 4-bit global

---
 rtl/rgb_palette_pwm_if.sv | 25 ++
 rtl/rgb_palette_pwm.sv | 148 ++++++++++++++
 tb/tb_rgb_palette_pwm.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/rgb_palette_pwm_if.sv
// Control and LED signal bundle for rgb_palette_pwm.
// Signalling: btn is a level, and each rising edge is one step request; there is no handshake back.
// Every other input is a level, sampled on every clk. All outputs are registered.
interface rgb_palette_pwm_if;
   logic       btn;
   logic       dir;
   logic       mode;
   logic [3:0] bright;
   logic       rgb_r;
   logic       rgb_g;
   logic       rgb_b;
   logic [2:0] color_idx;
   logic       frame_tick;
   logic       state_dbg;

   modport master (
      output btn, dir, mode, bright,
      input  rgb_r, rgb_g, rgb_b, color_idx, frame_tick, state_dbg
   );

   modport slave (
      input  btn, dir, mode, bright,
      output rgb_r, rgb_g, rgb_b, color_idx, frame_tick, state_dbg
   );
endinterface

// File: rtl/rgb_palette_pwm.sv
// RGB LED colour sequencer: palette lookup, brightness scaling, frame-synchronous duty
// reload and 8-bit PWM per channel, stepped by the button or by a frame timer.
module rgb_palette_pwm #(
   parameter int PRESCALE    = 3906,
   parameter int N_COLORS    = 7,
   parameter int AUTO_FRAMES = 100
) (
   input  logic              clk,
   input  logic              rst,
   rgb_palette_pwm_if.slave  bus
);
   localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam int AW = (AUTO_FRAMES > 1) ? $clog2(AUTO_FRAMES) : 1;
   localparam logic [PW-1:0] PRE_LAST  = PW'(PRESCALE - 1);
   localparam logic [AW-1:0] AUTO_LAST = AW'(AUTO_FRAMES - 1);
   localparam logic [2:0]    IDX_LAST  = 3'(N_COLORS - 1);

   typedef enum logic {S_MANUAL = 1'b0, S_AUTO = 1'b1} state_t;

   function automatic logic [23:0] palette(input logic [2:0] idx);
      case (idx)
         3'd0:    palette = 24'hFF0000;
         3'd1:    palette = 24'hFFA500;
         3'd2:    palette = 24'hFFFF00;
         3'd3:    palette = 24'h00FF00;
         3'd4:    palette = 24'h0000FF;
         3'd5:    palette = 24'h4B0082;
         3'd6:    palette = 24'hEE82EE;
         default: palette = 24'hFFFFFF;
      endcase
   endfunction

   // 255 * 16 = 4080 fits in 12 bits, so the top byte never saturates.
   function automatic logic [7:0] scale(input logic [7:0] c, input logic [3:0] b);
      logic [11:0] prod;
      prod  = 12'(c) * (12'(b) + 12'd1);
      scale = prod[11:4];
   endfunction

   logic [PW-1:0] pre_cnt_q, pre_cnt_d;
   logic [7:0]    pwm_cnt_q, pwm_cnt_d;
   logic          frame_tick_q, frame_tick_d;
   logic [7:0]    duty_r_q, duty_r_d, duty_g_q, duty_g_d, duty_b_q, duty_b_d;
   logic          rgb_r_q, rgb_r_d, rgb_g_q, rgb_g_d, rgb_b_q, rgb_b_d;
   logic          btn_prev_q, btn_prev_d;
   state_t        state_q, state_d;
   logic [AW-1:0] auto_cnt_q, auto_cnt_d;
   logic [2:0]    color_idx_q, color_idx_d;
   logic          pwm_tick, btn_edge, step;
   logic [23:0]   pal;

   always_comb begin
      pwm_tick     = (pre_cnt_q == PRE_LAST);
      pre_cnt_d    = pwm_tick ? '0 : pre_cnt_q + 1'b1;
      pwm_cnt_d    = pwm_tick ? pwm_cnt_q + 8'd1 : pwm_cnt_q;
      frame_tick_d = pwm_tick && (pwm_cnt_q == 8'hFF);
      pal          = palette(color_idx_q);
      duty_r_d     = duty_r_q;
      duty_g_d     = duty_g_q;
      duty_b_d     = duty_b_q;
      if (frame_tick_q) begin
         duty_r_d = scale(pal[23:16], bus.bright);
         duty_g_d = scale(pal[15:8],  bus.bright);
         duty_b_d = scale(pal[7:0],   bus.bright);
      end
      rgb_r_d    = (pwm_cnt_q < duty_r_q);
      rgb_g_d    = (pwm_cnt_q < duty_g_q);
      rgb_b_d    = (pwm_cnt_q < duty_b_q);
      btn_prev_d = bus.btn;
      btn_edge   = bus.btn & ~btn_prev_q;
   end

   always_comb begin
      state_d    = state_q;
      auto_cnt_d = auto_cnt_q;
      step       = 1'b0;
      case (state_q)
         S_MANUAL: begin
            step = btn_edge;
            if (bus.mode) begin
               state_d    = S_AUTO;
               auto_cnt_d = '0;
            end
         end
         S_AUTO: begin
            // A button edge wins over a coincident timer expiry: one step, timer restarts.
            if (btn_edge) begin
               step       = 1'b1;
               auto_cnt_d = '0;
            end else if (frame_tick_q) begin
               if (auto_cnt_q == AUTO_LAST) begin
                  step       = 1'b1;
                  auto_cnt_d = '0;
               end else begin
                  auto_cnt_d = auto_cnt_q + 1'b1;
               end
            end
            if (!bus.mode) state_d = S_MANUAL;
         end
         default: state_d = S_MANUAL;
      endcase

      color_idx_d = color_idx_q;
      if (step) begin
         if (bus.dir) color_idx_d = (color_idx_q == IDX_LAST) ? 3'd0 : color_idx_q + 3'd1;
         else         color_idx_d = (color_idx_q == 3'd0) ? IDX_LAST : color_idx_q - 3'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pre_cnt_q    <= '0;
         pwm_cnt_q    <= '0;
         frame_tick_q <= 1'b0;
         duty_r_q     <= '0;
         duty_g_q     <= '0;
         duty_b_q     <= '0;
         rgb_r_q      <= 1'b0;
         rgb_g_q      <= 1'b0;
         rgb_b_q      <= 1'b0;
         btn_prev_q   <= 1'b1;
         state_q      <= S_MANUAL;
         auto_cnt_q   <= '0;
         color_idx_q  <= '0;
      end else begin
         pre_cnt_q    <= pre_cnt_d;
         pwm_cnt_q    <= pwm_cnt_d;
         frame_tick_q <= frame_tick_d;
         duty_r_q     <= duty_r_d;
         duty_g_q     <= duty_g_d;
         duty_b_q     <= duty_b_d;
         rgb_r_q      <= rgb_r_d;
         rgb_g_q      <= rgb_g_d;
         rgb_b_q      <= rgb_b_d;
         btn_prev_q   <= btn_prev_d;
         state_q      <= state_d;
         auto_cnt_q   <= auto_cnt_d;
         color_idx_q  <= color_idx_d;
      end
   end

   assign bus.rgb_r      = rgb_r_q;
   assign bus.rgb_g      = rgb_g_q;
   assign bus.rgb_b      = rgb_b_q;
   assign bus.color_idx  = color_idx_q;
   assign bus.frame_tick = frame_tick_q;
   assign bus.state_dbg  = state_q;
endmodule

// File: tb/tb_rgb_palette_pwm.sv
// Directed bench for rgb_palette_pwm with PRESCALE=1 (256-clk frames) and AUTO_FRAMES=2.
module tb_rgb_palette_pwm;
   logic clk;
   logic rst;
   int   n_checks;
   int   n_errors;

   rgb_palette_pwm_if bus ();

   rgb_palette_pwm #(
      .PRESCALE    (1),
      .N_COLORS    (7),
      .AUTO_FRAMES (2)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // ---------------- clock / reset ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // ---------------- checking ----------------
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_btn();
      bus.btn = 1'b1;
      tick();
      bus.btn = 1'b0;
      tick();
   endtask

   // Returns sampled in the cycle where frame_tick is high.
   task automatic wait_frame();
      int n;
      n = 0;
      tick();
      while (!bus.frame_tick && n < 600) begin
         tick();
         n++;
      end
      if (n >= 600) check("frame_wait_timeout", 32'd0, 32'd1);
   endtask

   // Counts high cycles over one full frame whose duty was loaded at the next frame_tick.
   task automatic measure_frame(output int hr, output int hg, output int hb);
      hr = 0; hg = 0; hb = 0;
      wait_frame();
      @(posedge clk);
      for (int i = 0; i < 256; i++) begin
         tick();
         hr += int'(bus.rgb_r);
         hg += int'(bus.rgb_g);
         hb += int'(bus.rgb_b);
      end
   endtask

   // ---------------- stimulus + expected values ----------------
   initial begin
      int hr, hg, hb, n, exp_idx;
      n_checks = 0;
      n_errors = 0;
      rst        = 1'b1;
      bus.btn    = 1'b1;
      bus.dir    = 1'b1;
      bus.mode   = 1'b0;
      bus.bright = 4'd15;

      // 1. button held through reset
      repeat (3) tick();
      check("reset_rgb", {29'd0, bus.rgb_r, bus.rgb_g, bus.rgb_b}, 32'd0);
      check("reset_idx", bus.color_idx, 32'd0);
      check("reset_frame_tick", bus.frame_tick, 32'd0);
      rst = 1'b0;
      repeat (5) tick();
      check("held_btn_no_step", bus.color_idx, 32'd0);
      bus.btn = 1'b0;
      tick();

      // frame period
      wait_frame();
      n = 0;
      do begin
         tick();
         n++;
      end while (!bus.frame_tick && n < 600);
      check("frame_period", n, 32'd256);

      // 2. manual stepping with wrap both ways
      exp_idx = 0;
      for (int i = 0; i < 7; i++) begin
         pulse_btn();
         exp_idx = (exp_idx == 6) ? 0 : exp_idx + 1;
         check("manual_up", bus.color_idx, exp_idx);
      end
      bus.dir = 1'b0;
      repeat (5) tick();
      check("dir_change_no_move", bus.color_idx, 32'd0);
      pulse_btn();
      check("manual_down_wrap", bus.color_idx, 32'd6);
      bus.dir = 1'b1;
      pulse_btn();
      check("manual_up_wrap", bus.color_idx, 32'd0);

      // 3. red at full and half brightness
      measure_frame(hr, hg, hb);
      check("red_b15_r", hr, 32'd255);
      check("red_b15_g", hg, 32'd0);
      check("red_b15_b", hb, 32'd0);
      bus.bright = 4'd7;
      measure_frame(hr, hg, hb);
      check("red_b7_r", hr, 32'd127);

      // 4. indigo, then a brightness change in the middle of a frame
      bus.bright = 4'd15;
      repeat (5) pulse_btn();
      check("idx_five", bus.color_idx, 32'd5);
      measure_frame(hr, hg, hb);
      check("indigo_r", hr, 32'd75);
      check("indigo_g", hg, 32'd0);
      check("indigo_b", hb, 32'd130);
      wait_frame();
      @(posedge clk);
      hr = 0; hb = 0;
      for (int i = 0; i < 256; i++) begin
         tick();
         if (i == 100) bus.bright = 4'd7;
         hr += int'(bus.rgb_r);
         hb += int'(bus.rgb_b);
      end
      check("midframe_old_r", hr, 32'd75);
      check("midframe_old_b", hb, 32'd130);
      measure_frame(hr, hg, hb);
      check("newbright_r", hr, 32'd37);
      check("newbright_b", hb, 32'd65);

      // 5. auto mode: step every second frame_tick
      wait_frame();
      bus.mode = 1'b1;
      tick();
      check("auto_state", bus.state_dbg, 32'd1);
      wait_frame();
      tick();
      check("auto_first_tick_hold", bus.color_idx, 32'd5);
      wait_frame();
      tick();
      check("auto_step", bus.color_idx, 32'd6);
      wait_frame();
      repeat (256) tick();
      check("expiry_cycle_tick", bus.frame_tick, 32'd1);
      bus.btn = 1'b1;
      tick();
      bus.btn = 1'b0;
      check("expiry_plus_btn_single", bus.color_idx, 32'd0);
      wait_frame();
      tick();
      check("auto_cnt_cleared", bus.color_idx, 32'd0);
      wait_frame();
      tick();
      check("auto_step_after_clear", bus.color_idx, 32'd1);
      repeat (2) wait_frame();
      tick();
      check("auto_step_to_2", bus.color_idx, 32'd2);
      repeat (2) wait_frame();
      tick();
      check("auto_step_to_3", bus.color_idx, 32'd3);

      // 6. reset mid-frame in auto mode (frame running yellow at bright 7)
      repeat (40) tick();
      check("pre_reset_r_high", bus.rgb_r, 32'd1);
      rst = 1'b1;
      #1;
      check("async_reset_rgb", {29'd0, bus.rgb_r, bus.rgb_g, bus.rgb_b}, 32'd0);
      check("async_reset_idx", bus.color_idx, 32'd0);
      bus.mode = 1'b0;
      repeat (3) tick();
      rst = 1'b0;
      n = 0;
      hr = 0;
      do begin
         tick();
         n++;
         hr += int'(bus.rgb_r) + int'(bus.rgb_g) + int'(bus.rgb_b);
      end while (!bus.frame_tick && n < 600);
      check("post_reset_frame_start", n, 32'd256);
      check("post_reset_dark_frame", hr, 32'd0);
      check("post_reset_manual", bus.state_dbg, 32'd0);
      check("post_reset_idx", bus.color_idx, 32'd0);

      // ---------------- report ----------------
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
